// File: rtl/elementwise_mult_scheduler.sv
// Shares one N x N unsigned multiplier among NUM_REQ vector requesters.
// Round-robin arbitration picks a job in IDLE, the operands are captured, one
// element per cycle is multiplied in RUN, and the product vector is held on a
// valid/ready response port in RESP together with the owner ID and cycle cost.
module elementwise_mult_scheduler #(
  parameter int unsigned N       = 8,
  parameter int unsigned LEN     = 4,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*LEN*N-1:0]   req_a,
  input  logic [NUM_REQ*LEN*N-1:0]   req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [LEN*2*N-1:0]         resp_result,
  output logic                       busy,
  output logic [7:0]                 cycle_count
);

  localparam int unsigned PW    = 2 * N;
  localparam int unsigned LW    = LEN * N;
  localparam int unsigned RW    = LEN * PW;
  localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned CW    = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [RR_W-1:0]   r_rr;
  logic [ID_W-1:0]   r_id;
  logic [LW-1:0]     r_a;
  logic [LW-1:0]     r_b;
  logic [IDX_W-1:0]  r_idx;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_res;

  logic [LW-1:0]     w_req_a [NUM_REQ];
  logic [LW-1:0]     w_req_b [NUM_REQ];
  logic [N-1:0]      w_ea    [LEN];
  logic [N-1:0]      w_eb    [LEN];
  logic [PW-1:0]     w_prod;
  logic [RW-1:0]     w_res_next;
  logic              w_found;
  logic [RR_W-1:0]   w_grant;
  logic [RR_W-1:0]   w_cand;
  logic [RR_W-1:0]   w_rr_next;
  logic [NUM_REQ-1:0] w_ready;
  logic              w_accept;
  int                w_sum;
  int                w_inc;

  // Split the flat request buses into one operand vector per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_req_a[g] = req_a[g*LW +: LW];
    assign w_req_b[g] = req_b[g*LW +: LW];
  end

  // Split the captured operands into elements and build the next result vector
  for (genvar k = 0; k < LEN; k++) begin : g_elem
    assign w_ea[k] = r_a[k*N +: N];
    assign w_eb[k] = r_b[k*N +: N];
    assign w_res_next[k*PW +: PW] = (r_idx == IDX_W'(k)) ? w_prod : r_res[k*PW +: PW];
  end

  assign w_prod = PW'(w_ea[r_idx]) * PW'(w_eb[r_idx]);

  // Round-robin search starting at r_rr, wrapping at NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    w_sum   = 0;
    for (int off = 0; off < int'(NUM_REQ); off++) begin
      w_sum = int'(r_rr) + off;
      if (w_sum >= int'(NUM_REQ)) begin
        w_sum = w_sum - int'(NUM_REQ);
      end
      w_cand = RR_W'(w_sum);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Pointer to the requester after the current grant
  always_comb begin
    w_inc = int'(w_grant) + 1;
    if (w_inc >= int'(NUM_REQ)) begin
      w_inc = 0;
    end
    w_rr_next = RR_W'(w_inc);
  end

  // One-hot ready toward the granted requester, only while idle
  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_grant] = 1'b1;
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_next = S_RUN;
      S_RUN:  if (r_idx == IDX_W'(LEN - 1)) w_next = S_RESP;
      S_RESP: if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job capture, element stepping and cycle accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr  <= '0;
      r_id  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else if (w_accept) begin
      r_a   <= w_req_a[w_grant];
      r_b   <= w_req_b[w_grant];
      r_id  <= ID_W'(w_grant);
      r_rr  <= w_rr_next;
      r_idx <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else if (r_state == S_RUN) begin
      r_res <= w_res_next;
      r_idx <= r_idx + IDX_W'(1);
      if (r_cnt != {CW{1'b1}}) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign req_ready   = w_ready;
  assign resp_valid  = (r_state == S_RESP);
  assign busy        = (r_state != S_IDLE);
  assign resp_id     = r_id;
  assign resp_result = r_res;
  assign cycle_count = r_cnt;

endmodule

// File: tb/tb_elementwise_mult_scheduler.sv
// Directed bench for elementwise_mult_scheduler (N=8, LEN=4, NUM_REQ=2).
module tb_elementwise_mult_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0, a1, b0, b1;
  logic [63:0] req_a, req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [0:0]  resp_id;
  logic [63:0] resp_result;
  logic        busy;
  logic [7:0]  cycle_count;

  int checks;
  int failures;

  assign req_a = {a1, a0};
  assign req_b = {b1, b0};

  elementwise_mult_scheduler #(.N(8), .LEN(4), .NUM_REQ(2), .ID_W(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [7:0] e0, input logic [7:0] e1,
                                     input logic [7:0] e2, input logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [63:0] pr(input logic [15:0] p0, input logic [15:0] p1,
                                     input logic [15:0] p2, input logic [15:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  // Counts negedges until resp_valid is seen; -1 on timeout
  task automatic wait_resp(output int e);
    e = 0;
    while (!resp_valid && e < 20) begin
      @(negedge clk);
      e++;
    end
    if (!resp_valid) e = -1;
  endtask

  // Counts negedges until some req_ready bit is seen; -1 on timeout
  task automatic wait_ready(output int e);
    e = 0;
    while (req_ready == 2'b00 && e < 20) begin
      @(negedge clk);
      e++;
    end
    if (req_ready == 2'b00) e = -1;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || cycle_count !== 8'd0 ||
        resp_result !== 64'd0 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b cnt=%0d res=%h id=%b ready=%b, required all zero",
               resp_valid, busy, cycle_count, resp_result, resp_id, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e;
    logic [63:0] exp;
    exp = pr(16'd2, 16'd8, 16'd18, 16'd32);
    a0 = pk(8'd1, 8'd2, 8'd3, 8'd4);
    b0 = pk(8'd2, 8'd4, 8'd6, 8'd8);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL basic_ready: got %b required 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if (busy !== 1'b1 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL basic_busy: busy=%b ready=%b required 1/00", busy, req_ready);
    end
    wait_resp(e);
    checks++;
    if (e != 4) begin
      failures++;
      $display("FAIL basic_latency: got %0d required 4", e);
    end
    checks++;
    if (resp_result !== exp) begin
      failures++;
      $display("FAIL basic_result: got %h required %h", resp_result, exp);
    end
    checks++;
    if (resp_id !== 1'b0 || cycle_count !== 8'd4) begin
      failures++;
      $display("FAIL basic_id_count: id=%b cnt=%0d required 0/4", resp_id, cycle_count);
    end
    handshake();
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_result !== exp || cycle_count !== 8'd4) begin
      failures++;
      $display("FAIL basic_after_hs: valid=%b busy=%b res=%h cnt=%0d required 0/0/%h/4",
               resp_valid, busy, resp_result, cycle_count, exp);
    end
  endtask

  task automatic test_max_operands();
    int e;
    logic [63:0] exp;
    exp = {4{16'hFE01}};
    a0 = pk(8'd255, 8'd255, 8'd255, 8'd255);
    b0 = pk(8'd255, 8'd255, 8'd255, 8'd255);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL max_ready: got %b required 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    wait_resp(e);
    checks++;
    if (e != 4 || resp_result !== exp) begin
      failures++;
      $display("FAIL max_result: lat=%0d res=%h required 4/%h", e, resp_result, exp);
    end
    handshake();
  endtask

  task automatic test_round_robin();
    int e;
    logic [1:0]  exp_ready;
    logic [63:0] exp0, exp1, exp;
    exp0 = pr(16'd2, 16'd8, 16'd18, 16'd32);
    exp1 = pr(16'd30, 16'd60, 16'd90, 16'd120);
    rst_n = 1'b0;
    a0 = pk(8'd1, 8'd2, 8'd3, 8'd4);
    b0 = pk(8'd2, 8'd4, 8'd6, 8'd8);
    a1 = pk(8'd10, 8'd20, 8'd30, 8'd40);
    b1 = pk(8'd3, 8'd3, 8'd3, 8'd3);
    req_valid = 2'b11;
    resp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp_ready = (j % 2 == 0) ? 2'b01 : 2'b10;
      exp = (j % 2 == 0) ? exp0 : exp1;
      wait_ready(e);
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL rr_grant%0d: got %b required %b", j, req_ready, exp_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        failures++;
        $display("FAIL rr_pulse%0d: ready=%b busy=%b required 00/1", j, req_ready, busy);
      end
      wait_resp(e);
      checks++;
      if (e != 4 || resp_id !== exp_ready[1] || resp_result !== exp) begin
        failures++;
        $display("FAIL rr_resp%0d: lat=%0d id=%b res=%h required 4/%b/%h",
                 j, e, resp_id, resp_result, exp_ready[1], exp);
      end
    end
    req_valid = 2'b00;
    @(negedge clk);
    resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int e;
    logic [63:0] exp;
    exp = pr(16'd200, 16'd400, 16'd150, 16'd0);
    a1 = pk(8'd100, 8'd200, 8'd3, 8'd0);
    b1 = pk(8'd2, 8'd2, 8'd50, 8'd7);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b11;
    wait_resp(e);
    checks++;
    if (e != 4) begin
      failures++;
      $display("FAIL bp_latency: got %0d required 4", e);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_result !== exp ||
          req_ready !== 2'b00 || busy !== 1'b1 || cycle_count !== 8'd4) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b id=%b res=%h ready=%b busy=%b cnt=%0d required 1/1/%h/00/1/4",
                 c, resp_valid, resp_id, resp_result, req_ready, busy, cycle_count, exp);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    handshake();
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: valid=%b busy=%b required 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int e;
    logic [63:0] exp;
    exp = pr(16'd12, 16'd15, 16'd18, 16'd21);
    a0 = pk(8'd9, 8'd9, 8'd9, 8'd9);
    b0 = pk(8'd7, 8'd7, 8'd7, 8'd7);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || cycle_count !== 8'd0 ||
        resp_result !== 64'd0 || resp_id !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear: valid=%b busy=%b cnt=%0d res=%h id=%b required all zero",
               resp_valid, busy, cycle_count, resp_result, resp_id);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_noresp: valid=%b required 0", resp_valid);
    end
    rst_n = 1'b1;
    a0 = pk(8'd3, 8'd3, 8'd3, 8'd3);
    b0 = pk(8'd4, 8'd5, 8'd6, 8'd7);
    a1 = pk(8'd1, 8'd1, 8'd1, 8'd1);
    b1 = pk(8'd1, 8'd1, 8'd1, 8'd1);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL midrst_rr: got %b required 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    wait_resp(e);
    checks++;
    if (e != 4 || resp_id !== 1'b0 || resp_result !== exp || cycle_count !== 8'd4) begin
      failures++;
      $display("FAIL midrst_job: lat=%0d id=%b res=%h cnt=%0d required 4/0/%h/4",
               e, resp_id, resp_result, cycle_count, exp);
    end
    handshake();
  endtask

  task automatic test_operand_capture();
    int e;
    logic [63:0] exp;
    exp = pr(16'd45, 16'd60, 16'd77, 16'd96);
    a0 = pk(8'd5, 8'd6, 8'd7, 8'd8);
    b0 = pk(8'd9, 8'd10, 8'd11, 8'd12);
    req_valid = 2'b01;
    @(negedge clk);
    a0 = '0;
    b0 = '0;
    req_valid = 2'b00;
    wait_resp(e);
    checks++;
    if (e != 4 || resp_id !== 1'b0 || resp_result !== exp) begin
      failures++;
      $display("FAIL capture_result: lat=%0d id=%b res=%h required 4/0/%h",
               e, resp_id, resp_result, exp);
    end
    handshake();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_max_operands();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_operand_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
